// File: rtl/adaptor2x2_imem_arbiter.sv
// Two-master Avalon-MM arbiter for a single-port instruction RAM.
// m0 (fetch) has priority; a burst cap guarantees m1 (loader) progress.
module adaptor2x2_imem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int BE_W      = DATA_W / 8,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    output logic              mem_reset_req,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              req0;
    logic              req1;
    logic              issue_ok;
    logic              gnt0;
    logic              gnt1;
    logic              rd_issue;
    logic [CNT_W-1:0]  burst_cnt_q;
    logic [CNT_W-1:0]  burst_cnt_d;
    logic              rd_pend_q;
    logic              rd_pend_d;
    logic              rd_own_q;
    logic              rd_own_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    assign req0     = m0_read;
    assign req1     = m1_read | m1_write;
    assign issue_ok = ~reset & ~freeze;

    // Grant: m1 wins when m0 is idle or m0 has used up its burst allowance.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (issue_ok) begin
            if (req1 && (!req0 || burst_cnt_q == CNT_MAX)) begin
                gnt1 = 1'b1;
            end else if (req0) begin
                gnt0 = 1'b1;
            end
        end
    end

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    // Burst counter: counts m0 grants that made a waiting m1 stall.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (issue_ok) begin
            if (gnt0 && req1) begin
                if (burst_cnt_q != CNT_MAX) begin
                    burst_cnt_d = burst_cnt_q + CNT_ONE;
                end
            end else begin
                burst_cnt_d = '0;
            end
        end
    end

    // RAM issue mux; the address holds its last value between accesses.
    always_comb begin
        mem_address    = addr_q;
        mem_byteenable = '1;
        mem_write      = 1'b0;
        if (gnt0) begin
            mem_address = m0_address;
        end else if (gnt1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_write      = m1_write;
        end
    end

    assign mem_chipselect = gnt0 | gnt1;
    assign mem_writedata  = m1_writedata;
    assign mem_clken      = 1'b1;
    assign mem_reset_req  = reset;
    assign addr_d         = mem_address;

    // A read+write from m1 is a write, so it never creates a pending read.
    always_comb begin
        rd_issue  = gnt0 | (gnt1 & m1_read & ~m1_write);
        rd_pend_d = rd_issue;
        rd_own_d  = gnt1;
    end

    // Read-return tracking and burst state.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_own_q    <= 1'b0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_own_q    <= rd_own_d;
        end
    end

    // Last issued address, kept across idle and reset cycles.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
    end

    // Reset in the return cycle drops the pending read data.
    assign m0_readdatavalid = rd_pend_q & ~rd_own_q & ~reset;
    assign m1_readdatavalid = rd_pend_q & rd_own_q & ~reset;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_adaptor2x2_imem_arbiter.sv
// Directed-vector bench for adaptor2x2_imem_arbiter with a small RAM model.
// RAM: registered address, unregistered q, byte-lane writes.
module tb_adaptor2x2_imem_arbiter;

    logic        clk;
    logic        reset;
    logic        freeze;
    logic [9:0]  m0_address;
    logic        m0_read;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;
    logic [9:0]  m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_byteenable;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic        m1_readdatavalid;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic        mem_reset_req;
    logic [31:0] mem_readdata;

    int n_chk;
    int n_fail;

    adaptor2x2_imem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .freeze           (freeze),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_reset_req    (mem_reset_req),
        .mem_readdata     (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: word i initialised to 0xCAFE0000 | i.
    logic [31:0] ram [0:1023];
    logic [9:0]  addr_r;
    logic        ram_init;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'hCAFE0000 | 32'(i);
            addr_r <= '0;
        end else if (mem_clken && mem_chipselect) begin
            addr_r <= mem_address;
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
        end
    end

    assign mem_readdata = ram[addr_r];

    typedef struct {
        logic        rst;
        logic        frz;
        logic        r0;
        logic [9:0]  a0;
        logic        r1;
        logic        w1;
        logic [9:0]  a1;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        ew0;
        logic        ev0;
        logic        ew1;
        logic        ev1;
        logic        ecs;
        logic        ewe;
        logic        ca;
        logic [9:0]  ea;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic frz, input logic r0, input logic [9:0] a0,
        input logic r1, input logic w1, input logic [9:0] a1,
        input logic [31:0] wd, input logic [3:0] be,
        input logic ew0, input logic ev0, input logic ew1, input logic ev1,
        input logic ecs, input logic ewe, input logic ca,
        input logic [9:0] ea, input logic [31:0] ed);
        vec_t v;
        v.rst = rst; v.frz = frz; v.r0 = r0; v.a0 = a0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.wd = wd; v.be = be;
        v.ew0 = ew0; v.ev0 = ev0; v.ew1 = ew1; v.ev1 = ev1;
        v.ecs = ecs; v.ewe = ewe; v.ca = ca; v.ea = ea; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic frz, input logic r0,
                         input logic [9:0] a0, input logic r1, input logic w1,
                         input logic [9:0] a1, input logic [31:0] wd,
                         input logic [3:0] be);
        reset = rst; freeze = frz;
        m0_read = r0; m0_address = a0;
        m1_read = r1; m1_write = w1; m1_address = a1;
        m1_writedata = wd; m1_byteenable = be;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        ram_init = 1'b1;
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);

        // rst frz r0 a0 r1 w1 a1 wd be | w0 v0 w1 v1 cs we ca addr data
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1,0,1,0, 0,0,0,0,0, 1,0,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,1,10'h005,32'hDEADBEEF,4'b0011,
                          1,0,0,0,1,1,1,10'h005,0));
        vecs.push_back(mk(0,0,1,10'h005, 0,0,0,0,0, 0,0,1,0,1,0,1,10'h005,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 1,1,1,0,0,0,1,10'h005,32'hCAFEBEEF));
        vecs.push_back(mk(0,0,1,10'h007, 1,0,10'h009,0,0, 0,0,1,0,1,0,1,10'h007,0));
        vecs.push_back(mk(0,0,0,0, 1,0,10'h009,0,0, 1,1,0,0,1,0,1,10'h009,32'hCAFE0007));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 1,0,1,1,0,0,1,10'h009,32'hCAFE0009));
        vecs.push_back(mk(0,0,0,0, 1,1,10'h00A,32'h11223344,4'hF,
                          1,0,0,0,1,1,1,10'h00A,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 1,0,1,0,0,0,1,10'h00A,0));
        vecs.push_back(mk(0,0,1,10'h00A, 0,0,0,0,0, 0,0,1,0,1,0,1,10'h00A,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 1,1,1,0,0,0,1,10'h00A,32'h11223344));
        vecs.push_back(mk(0,0,1,10'h001, 0,0,0,0,0, 0,0,1,0,1,0,1,10'h001,0));
        vecs.push_back(mk(0,0,0,0, 1,0,10'h002,0,0, 1,1,0,0,1,0,1,10'h002,32'hCAFE0001));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 1,0,1,1,0,0,1,10'h002,32'hCAFE0002));
        vecs.push_back(mk(0,0,1,10'h003, 0,0,0,0,0, 0,0,1,0,1,0,1,10'h003,0));
        vecs.push_back(mk(1,0,1,10'h003, 0,0,0,0,0, 1,0,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,10'h004, 0,1,10'h006,0,0, 0,0,1,0,1,0,1,10'h004,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 1,1,1,0,0,0,1,10'h004,32'hCAFE0004));
        vecs.push_back(mk(0,0,1,10'h008, 0,0,0,0,0, 0,0,1,0,1,0,1,10'h008,0));
        vecs.push_back(mk(0,1,1,10'h008, 0,1,10'h006,0,0, 1,1,1,0,0,0,1,10'h008,32'hCAFE0008));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,1,1,10'h008, 0,1,10'h006,0,0, 1,0,1,0,0,0,1,10'h008,0));
        vecs.push_back(mk(0,0,1,10'h008, 0,1,10'h006,0,0, 0,0,1,0,1,0,1,10'h008,0));
        vecs.push_back(mk(0,0,0,0, 0,1,10'h006,0,0, 1,1,0,0,1,1,1,10'h006,32'hCAFE0008));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 1,0,1,0,0,0,1,10'h006,0));

        @(posedge clk);
        #1 ram_init = 1'b0;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk);
            drive(v.rst, v.frz, v.r0, v.a0, v.r1, v.w1, v.a1, v.wd, v.be);
            #2;
            chk($sformatf("v%0d m0_wait", i), 32'(m0_waitrequest), 32'(v.ew0));
            chk($sformatf("v%0d m1_wait", i), 32'(m1_waitrequest), 32'(v.ew1));
            chk($sformatf("v%0d m0_rdv", i), 32'(m0_readdatavalid), 32'(v.ev0));
            chk($sformatf("v%0d m1_rdv", i), 32'(m1_readdatavalid), 32'(v.ev1));
            chk($sformatf("v%0d cs", i), 32'(mem_chipselect), 32'(v.ecs));
            chk($sformatf("v%0d we", i), 32'(mem_write), 32'(v.ewe));
            chk($sformatf("v%0d rstreq", i), 32'(mem_reset_req), 32'(v.rst));
            chk($sformatf("v%0d clken", i), 32'(mem_clken), 32'd1);
            if (v.ca)
                chk($sformatf("v%0d addr", i), 32'(mem_address), 32'(v.ea));
            if (v.ev0)
                chk($sformatf("v%0d m0_rdata", i), m0_readdata, v.ed);
            if (v.ev1)
                chk($sformatf("v%0d m1_rdata", i), m1_readdata, v.ed);
            if (v.ewe) begin
                chk($sformatf("v%0d wdata", i), mem_writedata, v.wd);
                chk($sformatf("v%0d be", i), 32'(mem_byteenable), 32'(v.be));
            end
            if (!v.ew0)
                chk($sformatf("v%0d m0_be", i), 32'(mem_byteenable), 32'hF);
        end

        // Burst cap: m0 streams, m1 writes; m1 gets every 9th cycle.
        for (int i = 0; i < 18; i++) begin
            logic g1;
            logic ev;
            @(negedge clk);
            drive(0, 0, 1, 10'h010, 0, 1, 10'h020, 32'h55AA55AA, 4'hF);
            #2;
            g1 = (i == 8) || (i == 17);
            ev = (i > 0) && (i != 9);
            chk($sformatf("burst%0d m1_wait", i), 32'(m1_waitrequest), 32'(!g1));
            chk($sformatf("burst%0d m0_wait", i), 32'(m0_waitrequest), 32'(g1));
            chk($sformatf("burst%0d cs", i), 32'(mem_chipselect), 32'd1);
            chk($sformatf("burst%0d m0_rdv", i), 32'(m0_readdatavalid), 32'(ev));
            if (ev)
                chk($sformatf("burst%0d m0_rdata", i), m0_readdata, 32'hCAFE0010);
        end

        // Loader write landed: fetch it back.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("post_burst m0_rdv", 32'(m0_readdatavalid), 32'd0);
        @(negedge clk);
        drive(0, 0, 1, 10'h020, 0, 0, 0, 0, 0);
        #2;
        chk("rd20 m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("rd20 addr", 32'(mem_address), 32'h020);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rd20 m0_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("rd20 m0_rdata", m0_readdata, 32'h55AA55AA);
        chk("rd20 m1_rdv", 32'(m1_readdatavalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
